// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer: state and source
// encodings, vector addresses, the stack page and status-register bit
// positions, plus the helper that forms the pushed status byte.
package interrupt_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PUSH_PCH = 3'd1,
      ST_PUSH_PCL = 3'd2,
      ST_PUSH_PSR = 3'd3,
      ST_VEC_LO   = 3'd4,
      ST_VEC_HI   = 3'd5,
      ST_DONE     = 3'd6
   } state_e;

   // IRQ encodes as zero so the reset value of the source register is legal.
   typedef enum logic [1:0] {
      SRC_IRQ = 2'd0,
      SRC_BRK = 2'd1,
      SRC_NMI = 2'd2
   } src_e;

   localparam logic [15:0] VEC_NMI    = 16'hFFFA;
   localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
   localparam logic [7:0]  STACK_PAGE = 8'h01;

   localparam int unsigned PSR_I = 2;
   localparam int unsigned PSR_B = 4;
   localparam int unsigned PSR_5 = 5;

   // Bit 5 always reads as one on the stack; B distinguishes BRK from hardware.
   function automatic logic [7:0] push_psr(input logic [7:0] psr, input logic is_brk);
      logic [7:0] r;
      r        = psr;
      r[PSR_5] = 1'b1;
      r[PSR_B] = is_brk;
      return r;
   endfunction

endpackage

// File: rtl/intr_edge_detect.sv
// NMI falling-edge latch.
//   clk, rst_x  : clock, synchronous active-low reset
//   nmi_n_i     : raw NMI request (active-low)
//   clr_i       : clear the pending flag (NMI accepted)
//   pending_o   : an NMI edge has been seen and not yet serviced
module intr_edge_detect (
   input  logic clk,
   input  logic rst_x,
   input  logic nmi_n_i,
   input  logic clr_i,
   output logic pending_o
);

   logic prev_q;
   logic pending_q;
   logic fall;

   assign fall      = prev_q & ~nmi_n_i;
   assign pending_o = pending_q;

   always_ff @(posedge clk) begin
      if (!rst_x) begin
         prev_q    <= 1'b1;
         pending_q <= 1'b0;
      end else begin
         prev_q    <= nmi_n_i;
         // A fresh edge in the same cycle as the clear must not be lost.
         pending_q <= fall | (pending_q & ~clr_i);
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: on an instruction boundary, arbitrates NMI/BRK/IRQ,
// pushes PCH, PCL and PSR to the stack page, then fetches the two-byte vector
// and hands it to the register file.
//   clk, rst_x               : clock, synchronous active-low reset
//   nmi_n, irq_n, brk_req    : interrupt requests
//   boundary                 : instruction boundary pulse (only start point)
//   busy, done               : sequence status
//   mem_*                    : memory access handshake (held until mem_ack)
//   intr_s/intr_psr/intr_pc  : current SP, status and PC
//   intr_pushed              : push acknowledged, SP decrements
//   intr_data, intr_set_*    : vector byte and register-file load strobes
//
// state       | meaning
// ------------+-----------------------------------------
// ST_IDLE     | waiting for a boundary with a request
// ST_PUSH_PCH | writing PC high byte to stack
// ST_PUSH_PCL | writing PC low byte to stack
// ST_PUSH_PSR | writing status byte to stack
// ST_VEC_LO   | reading vector low byte, set I (and B)
// ST_VEC_HI   | reading vector high byte
// ST_DONE     | one-cycle completion pulse
module interrupt_sequencer
   import interrupt_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_x,
   input  logic        nmi_n,
   input  logic        irq_n,
   input  logic        brk_req,
   input  logic        boundary,
   output logic        busy,
   output logic        done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   input  logic [7:0]  intr_s,
   input  logic [7:0]  intr_psr,
   input  logic [15:0] intr_pc,
   output logic        intr_pushed,
   output logic [7:0]  intr_data,
   output logic        intr_set_pcl,
   output logic        intr_set_pch,
   output logic        intr_set_i,
   output logic        intr_set_b
);

   state_e      state_q, state_d;
   src_e        src_q, src_d;
   logic [15:0] pc_q, pc_d;
   logic        busy_q, done_q, mem_req_q, mem_we_q;
   logic        nmi_pending;
   logic        nmi_clr;
   logic        start;
   logic        is_push, is_vec;
   logic [15:0] vec_base;

   intr_edge_detect u_nmi (
      .clk       (clk),
      .rst_x     (rst_x),
      .nmi_n_i   (nmi_n),
      .clr_i     (nmi_clr),
      .pending_o (nmi_pending)
   );

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      pc_d    = pc_q;
      nmi_clr = 1'b0;
      start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (boundary) begin
               if (nmi_pending) begin
                  src_d   = SRC_NMI;
                  nmi_clr = 1'b1;
                  start   = 1'b1;
               end else if (brk_req) begin
                  src_d = SRC_BRK;
                  start = 1'b1;
               end else if (!irq_n && !intr_psr[PSR_I]) begin
                  src_d = SRC_IRQ;
                  start = 1'b1;
               end
            end
            if (start) begin
               pc_d    = intr_pc;
               state_d = ST_PUSH_PCH;
            end
         end
         ST_PUSH_PCH: if (mem_ack) state_d = ST_PUSH_PCL;
         ST_PUSH_PCL: if (mem_ack) state_d = ST_PUSH_PSR;
         ST_PUSH_PSR: if (mem_ack) state_d = ST_VEC_LO;
         ST_VEC_LO:   if (mem_ack) state_d = ST_VEC_HI;
         ST_VEC_HI:   if (mem_ack) state_d = ST_DONE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Status/handshake qualifiers are registered from the next state so they
   // line up with the state register without extra decode on the outputs.
   always_ff @(posedge clk) begin
      if (!rst_x) begin
         state_q   <= ST_IDLE;
         src_q     <= SRC_IRQ;
         pc_q      <= 16'h0000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         pc_q      <= pc_d;
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
         mem_req_q <= (state_d inside {ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_PSR,
                                        ST_VEC_LO, ST_VEC_HI});
         mem_we_q  <= (state_d inside {ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_PSR});
      end
   end

   assign is_push  = (state_q inside {ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_PSR});
   assign is_vec   = (state_q inside {ST_VEC_LO, ST_VEC_HI});
   assign vec_base = (src_q == SRC_NMI) ? VEC_NMI : VEC_IRQ;

   assign busy    = busy_q;
   assign done    = done_q;
   assign mem_req = mem_req_q;
   assign mem_we  = mem_we_q;

   // The stack address follows intr_s live so each SP decrement is seen by the
   // next push without a local copy.
   always_comb begin
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      case (state_q)
         ST_PUSH_PCH: begin
            mem_addr  = {STACK_PAGE, intr_s};
            mem_wdata = pc_q[15:8];
         end
         ST_PUSH_PCL: begin
            mem_addr  = {STACK_PAGE, intr_s};
            mem_wdata = pc_q[7:0];
         end
         ST_PUSH_PSR: begin
            mem_addr  = {STACK_PAGE, intr_s};
            mem_wdata = push_psr(intr_psr, src_q == SRC_BRK);
         end
         ST_VEC_LO: mem_addr = vec_base;
         ST_VEC_HI: mem_addr = {vec_base[15:1], 1'b1};
         default: ;
      endcase
   end

   assign intr_pushed  = is_push & mem_ack;
   assign intr_data    = (is_vec & mem_ack) ? mem_rdata : 8'h00;
   assign intr_set_pcl = (state_q == ST_VEC_LO) & mem_ack;
   assign intr_set_i   = (state_q == ST_VEC_LO) & mem_ack;
   assign intr_set_b   = (state_q == ST_VEC_LO) & mem_ack & (src_q == SRC_BRK);
   assign intr_set_pch = (state_q == ST_VEC_HI) & mem_ack;

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_x  in  1  reset, synchronous, active-low.
REQ-003 nmi_n  in  1  NMI request; falling edge latched.
REQ-004 irq_n  in  1  IRQ request; level, active-low.
REQ-005 brk_req  in  1  BRK request from execution controller; sampled only with boundary.
REQ-006 boundary  in  1  instruction boundary pulse; the only cycle a sequence may start.
REQ-007 busy  out  1  sequence in progress; decode/exec stalled while high.
REQ-008 done  out  1  one-cycle pulse; sequence complete.
REQ-009 mem_req  out  1  memory access request; held until mem_ack.
REQ-010 mem_we  out  1  1 = write (push), 0 = read (vector).
REQ-011 mem_addr  out  16  access address.
REQ-012 mem_wdata  out  8  push data.
REQ-013 mem_rdata  in  8  vector read data; valid with mem_ack.
REQ-014 mem_ack  in  1  access complete this cycle.
REQ-015 intr_s  in  8  current stack pointer from register file.
REQ-016 intr_psr  in  8  current status register.
REQ-017 intr_pc  in  16  current program counter.
REQ-018 intr_pushed  out  1  pulse per acknowledged push; register file decrements SP.
REQ-019 intr_data  out  8  vector byte to register file.
REQ-020 intr_set_pcl / intr_set_pch  out  1 each  load PCL / PCH from intr_data.
REQ-021 intr_set_i / intr_set_b  out  1 each  set I flag / set B flag.

Function
REQ-022 States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_LO, VEC_HI, DONE; busy = state != IDLE.
REQ-023 IDLE with boundary=1: NMI pending > brk_req > (irq_n=0 and intr_psr[2]=0); winner latched as source, intr_pc captured into pc_q, next state PUSH_PCH; no winner -> stay IDLE.
REQ-024 NMI pending set on nmi_n 1->0 (previous sample 1, current 0); cleared when NMI wins; a new edge in the accept cycle or during a sequence stays pending.
REQ-025 Push states: mem_req=1, mem_we=1, mem_addr={8'h01,intr_s}; wdata pc_q[15:8], pc_q[7:0], then PSR.
REQ-026 Pushed PSR = intr_psr with bit5=1 and bit4=1 for BRK, bit4=0 for IRQ/NMI.
REQ-027 Push ack: intr_pushed=1 for that cycle only, advance state; SP update is visible to next push address.
REQ-028 VEC_LO/VEC_HI: mem_req=1, mem_we=0, address FFFA/FFFB for NMI, FFFE/FFFF for IRQ/BRK.
REQ-029 VEC_LO ack: intr_data=mem_rdata, intr_set_pcl=1, intr_set_i=1, intr_set_b=1 if source BRK.
REQ-030 VEC_HI ack: intr_data=mem_rdata, intr_set_pch=1; next DONE.
REQ-031 DONE: done=1 for one cycle, mem_req=0, next IDLE; no acceptance in DONE.
REQ-032 No ack: state and all mem outputs held stable; wait unbounded.
REQ-033 Latency with mem_ack every cycle: boundary at cycle 0, five accesses in cycles 1-5, done in cycle 6, IDLE in cycle 7.
REQ-034 All intr_set_* / intr_pushed outputs are 0 outside their stated cycles; intr_data=0 when unused.

Reset
REQ-035 rst_x=0 at clock edge: state IDLE, NMI pending 0, nmi_n sample register 1, source/pc_q 0, all outputs 0 next cycle.
REQ-036 Reset mid-sequence aborts immediately; no further pushes or PC loads; an incomplete push is not retried.

Structure
REQ-037 Shared package: state encoding, source encoding, vectors 16'hFFFA/16'hFFFE, stack page 8'h01, PSR bit indices (I=2, B=4, bit5).
REQ-038 One sub-module, intr_edge_detect: NMI falling-edge latch with clear input.

Verification
REQ-039 intr_pc=1234, intr_s=FD, psr=20, irq_n=0, boundary pulse, ack every cycle -> writes 01FD=12, 01FC=34, 01FB=20; reads FFFE, FFFF; done in cycle 6.
REQ-040 Same with intr_psr[2]=1 -> no sequence, busy stays 0.
REQ-041 brk_req + boundary, psr=00 -> pushed PSR=30, intr_set_b with intr_set_pcl.
REQ-042 nmi_n falls during IRQ sequence -> after done, next boundary runs NMI via FFFA/FFFB; irq and brk both pending lose to NMI.
REQ-043 mem_ack withheld 3 cycles in PUSH_PCL -> mem_addr/wdata stable, single intr_pushed pulse.
REQ-044 rst_x=0 in VEC_LO -> next cycle IDLE, mem_req=0, no intr_set_pch ever asserted.
